// File: rtl/byte_word_stream_ctrl.sv
// Byte-to-word flow-control stage. Accepts bytes on a valid/ready handshake,
// drives the external shift register's enable, and after four accepted bytes
// captures the assembled 32-bit word into a first-word-fall-through FIFO.
module byte_word_stream_ctrl #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          sr_en,
  input  logic [31:0]   sr_word,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_data,
  output logic [1:0]    byte_cnt,
  output logic [AW:0]   fifo_count
);

  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [1:0]    byte_cnt_q, byte_cnt_d;
  logic          pending_q, pending_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [31:0]   mem_q [DEPTH];

  logic accept;
  logic push;
  logic pop;

  // Handshake decode. The fourth byte is only taken when a FIFO slot is
  // guaranteed, and nothing is taken while a capture is outstanding so the
  // shift register output stays stable for the write.
  always_comb begin
    in_ready = !pending_q && !((byte_cnt_q == 2'd3) && (count_q == FULL_COUNT));
    accept   = in_valid && in_ready;
    sr_en    = accept;
    push     = pending_q;
    out_valid = (count_q != '0);
    pop      = out_valid && out_ready;
  end

  // Next-state computation for counters, pointers and the capture flag.
  always_comb begin
    byte_cnt_d = byte_cnt_q;
    pending_d  = 1'b0;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;

    if (accept) begin
      byte_cnt_d = byte_cnt_q + 2'd1;
      pending_d  = (byte_cnt_q == 2'd3);
    end
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state register; reset discards any partial word.
  always_ff @(posedge clk) begin
    if (rst) begin
      byte_cnt_q <= '0;
      pending_q  <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      byte_cnt_q <= byte_cnt_d;
      pending_q  <= pending_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // FIFO storage; cleared on reset so the head reads zero when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push) begin
      mem_q[wr_ptr_q] <= sr_word;
    end
  end

  // Fall-through head and status outputs.
  always_comb begin
    out_data   = mem_q[rd_ptr_q];
    byte_cnt   = byte_cnt_q;
    fifo_count = count_q;
  end

endmodule

// File: tb/tb_byte_word_stream_ctrl.sv
// Self-checking bench for byte_word_stream_ctrl: includes a behavioural model
// of the external shift register, a queue-based reference model and directed
// scenarios with literal expectations.
module tb_byte_word_stream_ctrl;

  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic          sr_en;
  logic [31:0]   sr_word;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_data;
  logic [1:0]    byte_cnt;
  logic [AW:0]   fifo_count;
  logic [7:0]    in_byte;

  int n_tests = 0;
  int n_fail  = 0;
  bit check_en = 1'b0;

  always #5 clk = ~clk;

  byte_word_stream_ctrl #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .sr_en(sr_en),
    .sr_word(sr_word),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .byte_cnt(byte_cnt), .fifo_count(fifo_count)
  );

  // External shift register: newest byte enters at the bottom.
  logic [31:0] sr_q;
  always @(posedge clk) begin
    if (rst) sr_q <= '0;
    else if (sr_en) sr_q <= {sr_q[23:0], in_byte};
  end
  assign sr_word = sr_q;

  // Reference model state.
  logic [31:0] m_q[$];
  int          m_nbytes;
  logic [31:0] m_asm;
  logic [31:0] m_word;
  bit          m_pending;

  function automatic bit m_in_ready();
    return !m_pending && !(m_nbytes == 3 && m_q.size() == DEPTH);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance the model by one clock edge using the inputs applied this cycle.
  task automatic model_update();
    bit acc, pop;
    if (rst) begin
      m_q.delete();
      m_nbytes  = 0;
      m_asm     = '0;
      m_pending = 1'b0;
      return;
    end
    acc = in_valid && m_in_ready();
    pop = (m_q.size() > 0) && out_ready;
    if (pop) void'(m_q.pop_front());
    if (m_pending) m_q.push_back(m_word);
    m_pending = 1'b0;
    if (acc) begin
      m_asm = {m_asm[23:0], in_byte};
      if (m_nbytes == 3) begin
        m_word    = m_asm;
        m_pending = 1'b1;
      end
      m_nbytes = (m_nbytes + 1) % 4;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit ok = 1'b0;
    in_valid = 1'b1;
    in_byte  = b;
    for (int t = 0; t < 20 && !ok; t++) begin
      ok = m_in_ready();
      tick();
    end
    if (!ok) begin
      n_tests++;
      n_fail++;
      $display("FAIL accept_timeout: byte %h not accepted within 20 cycles", b);
    end
    in_valid = 1'b0;
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (check_en) begin
      chk("in_ready",   32'(in_ready),   32'(m_in_ready()));
      chk("sr_en",      32'(sr_en),      32'(in_valid && m_in_ready()));
      chk("out_valid",  32'(out_valid),  32'(m_q.size() != 0));
      chk("fifo_count", 32'(fifo_count), 32'(m_q.size()));
      chk("byte_cnt",   32'(byte_cnt),   32'(m_nbytes));
      if (m_q.size() != 0) chk("out_data", out_data, m_q[0]);
    end
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_byte = '0; out_ready = 1'b0;
    m_nbytes = 0; m_asm = '0; m_word = '0; m_pending = 1'b0;
    tick(); tick();
    rst = 1'b0;
    check_en = 1'b1;

    // Reset state
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_out_data",  out_data,       32'h0);
    chk("rst_fifo_count",32'(fifo_count),32'd0);
    chk("rst_byte_cnt",  32'(byte_cnt),  32'd0);

    // Basic pack
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_byte = 8'h11; tick();
    in_byte = 8'h22; tick();
    in_byte = 8'h33; tick();
    in_byte = 8'h44; tick();
    in_valid = 1'b0;
    chk("basic_in_ready_low", 32'(in_ready), 32'd0);
    tick();
    chk("basic_out_valid", 32'(out_valid), 32'd1);
    chk("basic_out_data",  out_data, 32'h11223344);
    tick();
    chk("basic_count_zero", 32'(fifo_count), 32'd0);
    $display("[TB] basic pack done");

    // Fill to full
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) send_byte(8'(i));
    tick();
    chk("fill_count", 32'(fifo_count), 32'd4);
    chk("fill_head",  out_data, 32'h00010203);
    send_byte(8'h10); send_byte(8'h11); send_byte(8'h12);
    chk("fill_byte_cnt3", 32'(byte_cnt), 32'd3);
    in_valid = 1'b1; in_byte = 8'h13;
    tick(); tick(); tick();
    chk("stall_in_ready", 32'(in_ready), 32'd0);
    chk("stall_sr_en",    32'(sr_en),    32'd0);
    chk("stall_byte_cnt", 32'(byte_cnt), 32'd3);
    out_ready = 1'b1; tick();
    out_ready = 1'b0;
    chk("release_in_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    $display("[TB] fill/stall done");

    // Simultaneous push and pop in the capture cycle
    out_ready = 1'b1; tick();
    chk("pushpop_count", 32'(fifo_count), 32'd3);
    chk("pushpop_head",  out_data, 32'h08090A0B);
    tick();
    chk("drain_head1", out_data, 32'h0C0D0E0F);
    tick();
    chk("drain_head2", out_data, 32'h10111213);
    tick();
    chk("drain_empty", 32'(out_valid), 32'd0);
    out_ready = 1'b0;
    $display("[TB] push/pop done");

    // Gapped input
    begin
      logic [7:0] gb [4];
      gb[0] = 8'hDE; gb[1] = 8'hAD; gb[2] = 8'hBE; gb[3] = 8'hEF;
      for (int i = 0; i < 4; i++) begin
        in_valid = 1'b1; in_byte = gb[i]; tick();
        chk("gap_byte_cnt", 32'(byte_cnt), 32'((i + 1) % 4));
        in_valid = 1'b0; tick();
      end
    end
    chk("gap_out_data", out_data, 32'hDEADBEEF);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    $display("[TB] gapped input done");

    // Reset mid-word
    send_byte(8'hAA); send_byte(8'hBB);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("midrst_byte_cnt",  32'(byte_cnt),  32'd0);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_in_ready",  32'(in_ready),  32'd1);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    tick();
    chk("midrst_out_data", out_data, 32'h01020304);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    $display("[TB] reset mid-word done");

    // Backpressure hold
    send_byte(8'hA0); send_byte(8'hA1); send_byte(8'hA2); send_byte(8'hA3);
    send_byte(8'hB0); send_byte(8'hB1); send_byte(8'hB2); send_byte(8'hB3);
    tick();
    chk("hold_count", 32'(fifo_count), 32'd2);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("hold_stable", out_data, 32'hA0A1A2A3);
    end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    chk("hold_next", out_data, 32'hB0B1B2B3);
    chk("hold_count1", 32'(fifo_count), 32'd1);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    tick();
    $display("[TB] backpressure done");

    check_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
